// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_pkt_pkg
//   Packet format shared by the core ports and the unified memory model.
//   The arbiter never looks inside a packet; it only moves it around.
// ---------------------------------------------------------------------------
package mem_pkt_pkg;

  localparam logic [1:0] MT_READ  = 2'd0;
  localparam logic [1:0] MT_WRITE = 2'd1;

  typedef struct packed {
    logic [1:0]  mtype;  // transaction kind (MT_READ / MT_WRITE / ...)
    logic [31:0] addr;   // byte address
    logic [3:0]  len;    // transfer length code
    logic [31:0] data;   // write data on requests, read data on responses
  } mem_pkt_t;

endpackage : mem_pkt_pkg

// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one downstream memory port between the instruction-fetch port
//   (imem) and the load/store port (dmem). One transaction is in flight at a
//   time. dmem normally wins, but after MAX_DMEM_STREAK consecutive dmem
//   grants taken while imem was waiting, imem is forced through so fetch
//   always makes progress.
//
//   Handshake rule (every port): a transfer happens on a cycle where
//   vld && rdy at the rising clock edge. A source holds vld and its packet
//   stable until the transfer. rdy may depend combinationally on vld.
//
// Parameters
//   MAX_DMEM_STREAK  dmem grants allowed back-to-back while imem waits (>= 1)
//   STREAK_W         width of the streak counter
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_vld/rdy/req          imem request channel
//   imem_rsp_vld/rdy/rsp          imem response channel
//   dmem_req_vld/rdy/req          dmem request channel
//   dmem_rsp_vld/rdy/rsp          dmem response channel
//   mem_req_vld/rdy/req           downstream request (mem_req is registered)
//   mem_rsp_vld/rdy/rsp           downstream response
//   owner                         requester owning the current transaction
//                                 (0 = imem, 1 = dmem), registered
//   busy                          a transaction is in progress (state != IDLE)
//   dbg_state                     raw FSM state: 0 IDLE, 1 ISSUE, 2 WAIT
//   dbg_streak                    current dmem streak count
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_pkt_pkg::*;
#(
  parameter int MAX_DMEM_STREAK = 4,
  parameter int STREAK_W        = $clog2(MAX_DMEM_STREAK + 1)
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                imem_req_vld,
  output logic                imem_req_rdy,
  input  mem_pkt_t            imem_req,
  output logic                imem_rsp_vld,
  input  logic                imem_rsp_rdy,
  output mem_pkt_t            imem_rsp,

  input  logic                dmem_req_vld,
  output logic                dmem_req_rdy,
  input  mem_pkt_t            dmem_req,
  output logic                dmem_rsp_vld,
  input  logic                dmem_rsp_rdy,
  output mem_pkt_t            dmem_rsp,

  output logic                mem_req_vld,
  input  logic                mem_req_rdy,
  output mem_pkt_t            mem_req,
  input  logic                mem_rsp_vld,
  output logic                mem_rsp_rdy,
  input  mem_pkt_t            mem_rsp,

  output logic                owner,
  output logic                busy,
  output logic [1:0]          dbg_state,
  output logic [STREAK_W-1:0] dbg_streak
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a request
    ISSUE = 2'd1,  // captured request presented downstream
    WAIT  = 2'd2   // waiting for the downstream response
  } state_t;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DMEM_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  state_t              state;
  logic [STREAK_W-1:0] streak;

  // Arbitration decision, only meaningful while in IDLE.
  logic streak_full;
  logic dmem_win;
  logic imem_win;

  // Qualified state decodes. Gating with rst keeps every handshake output
  // quiet during the reset cycle even though the state register only clears
  // at the following edge.
  logic in_idle;
  logic in_issue;
  logic in_wait;

  always_comb begin
    streak_full = (streak == STREAK_MAX);
    // dmem wins unless imem is waiting and has already been passed over
    // MAX_DMEM_STREAK times in a row.
    dmem_win    = dmem_req_vld && !(imem_req_vld && streak_full);
    imem_win    = !dmem_win && imem_req_vld;

    in_idle     = !rst && (state == IDLE);
    in_issue    = !rst && (state == ISSUE);
    in_wait     = !rst && (state == WAIT);
  end

  // -------------------------------------------------------------------------
  // Handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req_rdy = 1'b0;
    dmem_req_rdy = 1'b0;
    mem_req_vld  = 1'b0;
    mem_rsp_rdy  = 1'b1;
    imem_rsp_vld = 1'b0;
    dmem_rsp_vld = 1'b0;

    // Only the winner sees rdy; the loser keeps holding its request.
    if (in_idle) begin
      imem_req_rdy = imem_win;
      dmem_req_rdy = dmem_win;
    end

    if (in_issue) begin
      mem_req_vld = 1'b1;
    end

    // In WAIT the response is passed straight through to the owner, so the
    // owner's backpressure stalls the downstream port. Outside WAIT (and
    // during reset) mem_rsp_rdy stays high so stray responses left over from
    // an abandoned transaction are drained and dropped.
    if (in_wait) begin
      mem_rsp_rdy  = owner ? dmem_rsp_rdy : imem_rsp_rdy;
      imem_rsp_vld = !owner && mem_rsp_vld;
      dmem_rsp_vld =  owner && mem_rsp_vld;
    end
  end

  // Both response buses carry the downstream packet; the valids select.
  assign imem_rsp   = mem_rsp;
  assign dmem_rsp   = mem_rsp;

  assign busy       = (state != IDLE);
  assign dbg_state  = state;
  assign dbg_streak = streak;

  // -------------------------------------------------------------------------
  // FSM, captured request, owner and streak counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Any in-flight transaction is simply abandoned.
      state   <= IDLE;
      owner   <= 1'b0;
      streak  <= '0;
      mem_req <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dmem_win) begin
            mem_req <= dmem_req;
            owner   <= 1'b1;
            state   <= ISSUE;
            // Count only dmem grants that made imem wait. dmem_win with
            // imem pending implies streak < STREAK_MAX, so no overflow.
            if (imem_req_vld) begin
              streak <= streak + STREAK_ONE;
            end else begin
              streak <= '0;
            end
          end else if (imem_win) begin
            mem_req <= imem_req;
            owner   <= 1'b0;
            state   <= ISSUE;
            streak  <= '0;
          end else begin
            // Nothing pending: imem is not waiting, so the streak resets.
            streak <= '0;
          end
        end

        ISSUE: begin
          // mem_req is held; wait as long as downstream needs.
          if (mem_req_rdy) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (mem_rsp_vld && mem_rsp_rdy) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Tests push the expected grant order,
//   downstream request packets and routed responses into queues; a monitor
//   process pops and compares whenever the DUT shows a handshake. A small
//   memory responder answers each downstream request one cycle later with
//   the next packet from rsp_q. Inputs are driven 1 time unit after the
//   rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_pkt_pkg::*;

  localparam int MAX_STREAK = 4;
  localparam int STREAK_W   = $clog2(MAX_STREAK + 1);
  localparam int PKT_W      = $bits(mem_pkt_t);

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT wiring
  logic                imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
  logic                dmem_req_vld, dmem_req_rdy, dmem_rsp_vld, dmem_rsp_rdy;
  logic                mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
  mem_pkt_t            imem_req, imem_rsp, dmem_req, dmem_rsp, mem_req, mem_rsp;
  logic                owner, busy;
  logic [1:0]          dbg_state;
  logic [STREAK_W-1:0] dbg_streak;

  mem_port_arbiter #(.MAX_DMEM_STREAK(MAX_STREAK)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_vld (imem_req_vld),
    .imem_req_rdy (imem_req_rdy),
    .imem_req     (imem_req),
    .imem_rsp_vld (imem_rsp_vld),
    .imem_rsp_rdy (imem_rsp_rdy),
    .imem_rsp     (imem_rsp),
    .dmem_req_vld (dmem_req_vld),
    .dmem_req_rdy (dmem_req_rdy),
    .dmem_req     (dmem_req),
    .dmem_rsp_vld (dmem_rsp_vld),
    .dmem_rsp_rdy (dmem_rsp_rdy),
    .dmem_rsp     (dmem_rsp),
    .mem_req_vld  (mem_req_vld),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req      (mem_req),
    .mem_rsp_vld  (mem_rsp_vld),
    .mem_rsp_rdy  (mem_rsp_rdy),
    .mem_rsp      (mem_rsp),
    .owner        (owner),
    .busy         (busy),
    .dbg_state    (dbg_state),
    .dbg_streak   (dbg_streak)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [0:0]       exp_grant_q[$];  // requester id: 0 imem, 1 dmem
  logic [PKT_W-1:0] exp_issue_q[$];  // packets expected on mem_req
  logic [PKT_W:0]   exp_rsp_q[$];    // {requester id, packet} routed back
  mem_pkt_t         rsp_q[$];        // responder stimulus

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_grants = 0;
  logic owner_pend = 1'b0;
  logic owner_exp  = 1'b0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected or never happened (t=%0t)", name, $time);
  endtask

  function automatic mem_pkt_t mk(input logic [1:0] t, input logic [31:0] a,
                                  input logic [3:0] l, input logic [31:0] d);
    mem_pkt_t p;
    p.mtype = t;
    p.addr  = a;
    p.len   = l;
    p.data  = d;
    return p;
  endfunction

  task automatic expect_txn(input logic id, input mem_pkt_t req, input mem_pkt_t rsp);
    exp_grant_q.push_back(id);
    exp_issue_q.push_back(req);
    rsp_q.push_back(rsp);
    exp_rsp_q.push_back({id, rsp});
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    forever begin
      @(negedge clk);
      if (owner_pend) begin
        check("owner_after_grant", 128'(owner), 128'(owner_exp));
        owner_pend = 1'b0;
      end
      if (!rst) begin
        check("req_rdy_onehot", 128'(imem_req_rdy & dmem_req_rdy), 128'(0));
        check("rsp_vld_onehot", 128'(imem_rsp_vld & dmem_rsp_vld), 128'(0));
        if (imem_req_vld && imem_req_rdy) begin
          if (exp_grant_q.size() == 0) fail_now("unexpected_imem_grant");
          else check("grant_order", 128'(1'b0), 128'(exp_grant_q.pop_front()));
          owner_pend = 1'b1;
          owner_exp  = 1'b0;
          n_grants++;
        end
        if (dmem_req_vld && dmem_req_rdy) begin
          if (exp_grant_q.size() == 0) fail_now("unexpected_dmem_grant");
          else check("grant_order", 128'(1'b1), 128'(exp_grant_q.pop_front()));
          owner_pend = 1'b1;
          owner_exp  = 1'b1;
          n_grants++;
        end
        if (mem_req_vld && mem_req_rdy) begin
          if (exp_issue_q.size() == 0) fail_now("unexpected_mem_req");
          else check("mem_req_pkt", 128'(mem_req), 128'(exp_issue_q.pop_front()));
        end
        if (imem_rsp_vld && imem_rsp_rdy) begin
          if (exp_rsp_q.size() == 0) fail_now("unexpected_imem_rsp");
          else check("imem_rsp", 128'({1'b0, imem_rsp}), 128'(exp_rsp_q.pop_front()));
        end
        if (dmem_rsp_vld && dmem_rsp_rdy) begin
          if (exp_rsp_q.size() == 0) fail_now("unexpected_dmem_rsp");
          else check("dmem_rsp", 128'({1'b1, dmem_rsp}), 128'(exp_rsp_q.pop_front()));
        end
      end
    end
  end

  // ---------------------------------------------------------------- memory responder
  logic     rsp_enable = 1'b1;
  logic     rsp_vld_r  = 1'b0;
  mem_pkt_t rsp_pkt_r  = '0;
  logic     stray_vld  = 1'b0;
  mem_pkt_t stray_pkt  = '0;

  assign mem_rsp_vld = rsp_vld_r | stray_vld;
  assign mem_rsp     = stray_vld ? stray_pkt : rsp_pkt_r;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mem_req_vld && mem_req_rdy && rsp_enable) begin
        int n;
        @(posedge clk);
        #1;
        rsp_vld_r = 1'b1;
        rsp_pkt_r = (rsp_q.size() != 0) ? rsp_q.pop_front() : '0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!mem_rsp_rdy && n < 500);
        if (!mem_rsp_rdy) fail_now("rsp_handshake_timeout");
        @(posedge clk);
        #1;
        rsp_vld_r = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // Caller is positioned 1 unit after a rising edge.
  task automatic drive_req(input logic is_d, input mem_pkt_t p);
    int  n;
    logic acc;
    if (is_d) begin dmem_req_vld = 1'b1; dmem_req = p; end
    else      begin imem_req_vld = 1'b1; imem_req = p; end
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = is_d ? dmem_req_rdy : imem_req_rdy;
      n++;
    end
    if (!acc) fail_now(is_d ? "dmem_accept_timeout" : "imem_accept_timeout");
    @(posedge clk);
    #1;
    if (is_d) dmem_req_vld = 1'b0;
    else      imem_req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || mem_rsp_vld) && n < 300);
    check("wait_idle_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != s && n < 300);
    check(name, 128'(dbg_state), 128'(s));
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- tests
  mem_pkt_t pi, pd, ri, rd;
  mem_pkt_t sd[6];
  mem_pkt_t si[2];
  logic     order_id[8];
  int       grant_target;

  initial begin
    rst          = 1'b1;
    imem_req_vld = 1'b0; imem_req = '0; imem_rsp_rdy = 1'b1;
    dmem_req_vld = 1'b0; dmem_req = '0; dmem_rsp_rdy = 1'b1;
    mem_req_rdy  = 1'b1;

    // --- reset: handshake outputs quiet, drain ready, registers cleared
    @(posedge clk); #1;
    imem_req_vld = 1'b1;
    dmem_req_vld = 1'b1;
    @(negedge clk);
    check("rst_imem_req_rdy", 128'(imem_req_rdy), 128'(0));
    check("rst_dmem_req_rdy", 128'(dmem_req_rdy), 128'(0));
    check("rst_mem_req_vld",  128'(mem_req_vld),  128'(0));
    check("rst_mem_rsp_rdy",  128'(mem_rsp_rdy),  128'(1));
    @(posedge clk); #1;
    imem_req_vld = 1'b0;
    dmem_req_vld = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    check("rst_busy",   128'(busy),       128'(0));
    check("rst_owner",  128'(owner),      128'(0));
    check("rst_mem_req",128'(mem_req),    128'(0));
    check("rst_streak", 128'(dbg_streak), 128'(0));
    @(posedge clk); #1;

    // --- imem only, cycle-exact latency
    pi = mk(MT_READ, 32'h100, 4'd1, 32'h0);
    ri = mk(MT_READ, 32'h100, 4'd1, 32'hDEADBEEF);
    expect_txn(1'b0, pi, ri);
    imem_req_vld = 1'b1;
    imem_req     = pi;
    @(negedge clk);                                   // cycle 0
    check("t1_c0_imem_req_rdy", 128'(imem_req_rdy), 128'(1));
    check("t1_c0_dmem_rsp_vld", 128'(dmem_rsp_vld), 128'(0));
    @(posedge clk); #1;
    imem_req_vld = 1'b0;
    @(negedge clk);                                   // cycle 1
    check("t1_c1_mem_req_vld",  128'(mem_req_vld),  128'(1));
    check("t1_c1_mem_req_addr", 128'(mem_req.addr), 128'(32'h100));
    check("t1_c1_dmem_rsp_vld", 128'(dmem_rsp_vld), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);                                   // cycle 2
    check("t1_c2_imem_rsp_vld",  128'(imem_rsp_vld),  128'(1));
    check("t1_c2_imem_rsp_data", 128'(imem_rsp.data), 128'(32'hDEADBEEF));
    check("t1_c2_dmem_rsp_vld",  128'(dmem_rsp_vld),  128'(0));
    wait_idle();

    // --- simultaneous requests: dmem first, then imem
    pi = mk(MT_READ,  32'h200, 4'd1, 32'h0);
    pd = mk(MT_WRITE, 32'h400, 4'd1, 32'h12345678);
    rd = mk(MT_WRITE, 32'h400, 4'd1, 32'h0);
    ri = mk(MT_READ,  32'h200, 4'd1, 32'hCAFEF00D);
    expect_txn(1'b1, pd, rd);
    expect_txn(1'b0, pi, ri);
    fork
      drive_req(1'b1, pd);
      drive_req(1'b0, pi);
    join
    wait_idle();

    // --- starvation limit: D D D D I D (streak 1) D I
    for (int k = 0; k < 6; k++) sd[k] = mk(MT_WRITE, 32'h1000 + 32'(4 * k), 4'd1, 32'hD0 + 32'(k));
    for (int k = 0; k < 2; k++) si[k] = mk(MT_READ,  32'h2000 + 32'(4 * k), 4'd1, 32'h0);
    order_id = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    begin
      int di, ii;
      di = 0;
      ii = 0;
      for (int k = 0; k < 8; k++) begin
        if (order_id[k]) begin
          expect_txn(1'b1, sd[di], mk(MT_WRITE, sd[di].addr, 4'd1, 32'hA0000000 + 32'(k)));
          di++;
        end else begin
          expect_txn(1'b0, si[ii], mk(MT_READ, si[ii].addr, 4'd1, 32'hA0000000 + 32'(k)));
          ii++;
        end
      end
    end
    grant_target = n_grants + 6;
    fork
      begin
        for (int k = 0; k < 6; k++) drive_req(1'b1, sd[k]);
      end
      begin
        drive_req(1'b0, si[0]);
        drive_req(1'b0, si[1]);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (n_grants < grant_target && n < 500);
        @(negedge clk);
        check("t3_streak_after_6th_grant", 128'(dbg_streak), 128'(1));
      end
    join
    wait_idle();

    // --- backpressure in ISSUE (5 cycles) and in WAIT (3 cycles)
    pd = mk(MT_WRITE, 32'h500, 4'd2, 32'h55AA55AA);
    pi = mk(MT_READ,  32'h600, 4'd1, 32'h0);
    rd = mk(MT_WRITE, 32'h500, 4'd2, 32'h0);
    ri = mk(MT_READ,  32'h600, 4'd1, 32'h600DF00D);
    expect_txn(1'b1, pd, rd);
    expect_txn(1'b0, pi, ri);
    mem_req_rdy  = 1'b0;
    dmem_rsp_rdy = 1'b0;
    fork
      drive_req(1'b1, pd);
      drive_req(1'b0, pi);
      begin
        wait_state(2'd1, "t4_reach_issue");
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("t4_issue_mem_req_vld", 128'(mem_req_vld),  128'(1));
          check("t4_issue_mem_req",     128'(mem_req),      128'(pd));
          check("t4_issue_imem_rdy",    128'(imem_req_rdy), 128'(0));
        end
        @(posedge clk); #1;
        mem_req_rdy = 1'b1;
        @(negedge clk);
        check("t4_handshake_mem_req", 128'(mem_req), 128'(pd));
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("t4_wait_mem_rsp_rdy",  128'(mem_rsp_rdy),  128'(0));
          check("t4_wait_dmem_rsp_vld", 128'(dmem_rsp_vld), 128'(1));
          check("t4_wait_imem_rdy",     128'(imem_req_rdy), 128'(0));
          @(posedge clk); #1;
        end
        dmem_rsp_rdy = 1'b1;
      end
    join
    wait_idle();

    // --- reset in WAIT, stray response drained, then normal service
    pd = mk(MT_WRITE, 32'h700, 4'd1, 32'h77777777);
    exp_grant_q.push_back(1'b1);
    exp_issue_q.push_back(pd);
    rsp_enable = 1'b0;
    drive_req(1'b1, pd);
    wait_state(2'd2, "t5_reach_wait");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_mem_rsp_rdy", 128'(mem_rsp_rdy), 128'(1));
    check("t5_rst_mem_req_vld", 128'(mem_req_vld), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_after_rst_busy",    128'(busy),    128'(0));
    check("t5_after_rst_owner",   128'(owner),   128'(0));
    check("t5_after_rst_mem_req", 128'(mem_req), 128'(0));
    @(posedge clk); #1;
    stray_vld = 1'b1;
    stray_pkt = mk(MT_WRITE, 32'h700, 4'd1, 32'hBAD0BAD0);
    @(negedge clk);
    check("t5_stray_mem_rsp_rdy",  128'(mem_rsp_rdy),  128'(1));
    check("t5_stray_imem_rsp_vld", 128'(imem_rsp_vld), 128'(0));
    check("t5_stray_dmem_rsp_vld", 128'(dmem_rsp_vld), 128'(0));
    check("t5_stray_busy",         128'(busy),         128'(0));
    @(posedge clk); #1;
    stray_vld = 1'b0;
    @(negedge clk);
    check("t5_post_stray_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rsp_enable = 1'b1;
    pi = mk(MT_READ, 32'h800, 4'd1, 32'h0);
    ri = mk(MT_READ, 32'h800, 4'd1, 32'hBADC0FFE);
    expect_txn(1'b0, pi, ri);
    drive_req(1'b0, pi);
    wait_idle();

    // --- everything expected was seen
    check("exp_grant_q_empty", 128'(exp_grant_q.size()), 128'(0));
    check("exp_issue_q_empty", 128'(exp_issue_q.size()), 128'(0));
    check("exp_rsp_q_empty",   128'(exp_rsp_q.size()),   128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
